insn_encode: RTL and testbench
==============================

Name: insn_encode

Overview:
- Streaming RISC-V RV32I instruction encoder, the inverse of the core's field decoder.
- Accepts per-field tuples plus a format selector and packs them into 32-bit instruction words.
- Checks immediate range and alignment, then buffers results in an output FIFO.
- Sits between the test/boot-ROM generator (or debug-module program-buffer writer) and instruction memory.

Parameters:
- DEPTH, 4: output FIFO entries; power of two, ≥2.
- LVL_W, $clog2(DEPTH)+1: width of the level output (derived, not overridden).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- flush  input  1  synchronous FIFO clear.
- in_valid  input  1  input tuple valid.
- in_ready  output  1  encoder can accept a tuple.
- in_fmt  input  3  0=R 1=I 2=S 3=B 4=U 5=J; 6 and 7 are illegal.
- in_opcode  input  7  opcode field.
- in_rd  input  5  destination register.
- in_funct3  input  3  funct3 field.
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2.
- in_funct7  input  7  funct7 field.
- in_imm  input  32  signed byte-offset/value; U uses the full 32-bit value.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts the head.
- out_insn  output  32  encoded word.
- out_err  output  1  head word has a range, alignment or format error.
- level  output  LVL_W  FIFO occupancy.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, pointers 0, out_valid=0, out_insn=0, out_err=0, level=0, in_ready=1 one edge after release.
- Write: when in_valid && in_ready, the combinational encoding is written into the FIFO.
- Read: when out_valid && out_ready, the head is popped.
- Latency: 1 cycle from accept to out_valid when empty; no same-cycle pass-through.
- Handshake:
  - in_ready = (level < DEPTH); when full, in_ready=0 even if out_ready=1 that cycle.
  - out_valid = (level != 0); out_insn/out_err stable while out_valid && !out_ready.
- Simultaneous push and pop when not full and not empty: level unchanged.
- Pointers wrap modulo DEPTH; level counts 0..DEPTH.
- flush has priority over push and pop: level=0, pointers 0 next cycle, any same-cycle write is dropped; in_ready stays per the pre-flush level that cycle.
- Packing:
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
- Fields not used by a format are ignored.
- Error rules, all under INSN_ENCODE_CHECK_EN:
  - I/S: imm outside [-2048, 2047].
  - B: imm outside [-4096, 4094], or imm[0]=1.
  - J: imm outside [-1048576, 1048574], or imm[0]=1.
  - U: imm[11:0] != 0.
  - R: never an error.
- Illegal fmt (6/7): out_insn=0, out_err=1 regardless of the macro.
- Erroneous words are still written, with bits truncated per the packing rule.

Optional Feature:
- INSN_ENCODE_CHECK_EN defined: range/alignment checks as above, stored per entry.
- Undefined: the checker is not compiled; out_err is set only for illegal fmt; the FIFO error bit is kept.

Decomposition:
- Shared package insn_pkg:
  - fmt_e enum (FMT_R..FMT_J).
  - Opcode constants OP_LUI, OP_JAL, OP_BRANCH, OP_STORE, OP_OP_IMM, OP_OP.
  - Immediate bound localparams.
- The decoder shares the same package.
- Sub-module insn_fifo: generic DEPTH x WIDTH synchronous FIFO with flush and level.
- Encode and check logic is combinational inside insn_encode.

Test Plan:
- Format packing, out_ready=1 throughout:
  - I opcode 0x13, rd=1, f3=0, rs1=0, imm=5 -> 0x00500093, err=0, one cycle after accept.
  - R opcode 0x33, rd=3, rs1=1, rs2=2, f7=0 -> 0x002081B3.
  - S opcode 0x23, f3=2, rs1=1, rs2=2, imm=8 -> 0x0020A423.
- B/U/J: B opcode 0x63, rs1=1, rs2=2, imm=-4 -> 0xFE208EE3; U opcode 0x37, rd=5, imm=0x12345000 -> 0x123452B7; J with imm=3 -> err=1 (macro on).
- Errors: I imm=4096 -> err=1 with macro, 0 without; fmt=7 -> insn=0, err=1 in both builds.
- Backpressure (DEPTH=4), out_ready=0: push 4 -> level=4, in_ready=0; 5th tuple held until one pop frees a slot; output order preserved across pointer wrap after 10 pushes.
- Flush: level=3 plus a same-cycle push with flush=1 -> level=0, out_valid=0 next cycle, dropped word never appears.
- Reset: assert rst_n=0 mid-stream with level=2 -> immediately out_valid=0, level=0; after release, first push appears 1 cycle later.

Source files
------------

// File: rtl/insn_pkg.sv
// Shared RV32I encode/decode definitions: instruction format selector, major opcode
// constants and signed immediate bounds for each immediate-bearing format.
package insn_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_OP_IMM = 7'h13;
  localparam logic [6:0] OP_OP     = 7'h33;

  // Inclusive signed ranges of the byte offsets/values each format can represent.
  localparam int IMM_I_MIN = -2048;
  localparam int IMM_I_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -1048576;
  localparam int IMM_J_MAX = 1048574;

  function automatic logic imm_in_range(input logic [31:0] imm, input int lo, input int hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

endpackage

// File: rtl/insn_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with flush and occupancy count.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   flush_i         synchronous clear; beats push and pop
//   push_i/wdata_i  write request (ignored when full)
//   pop_i           read request (ignored when empty)
//   rdata_o         head entry, zero when empty
//   full_o/empty_o  status
//   level_o         occupancy 0..DEPTH
module insn_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 33
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LvlW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      level_d = level_q + LvlW'(do_push) - LvlW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/insn_encode.sv
// Streaming RV32I instruction encoder: packs per-field tuples into 32-bit words
// according to in_fmt and queues {err, word} in an output FIFO.
// Build option: define INSN_ENCODE_CHECK_EN to flag out-of-range or misaligned
// immediates; without it only illegal formats (6/7) raise out_err.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   flush                    synchronous FIFO clear (drops same-cycle write)
//   in_valid/in_ready        input tuple handshake
//   in_fmt..in_imm           format selector and instruction fields
//   out_valid/out_ready      output word handshake
//   out_insn, out_err        FIFO head word and its error flag
//   level                    FIFO occupancy
module insn_encode
  import insn_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [2:0]       in_funct3,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_insn,
  output logic             out_err,
  output logic [LVL_W-1:0] level
);

  fmt_e        fmt;
  logic [31:0] enc_insn;
  logic        fmt_err;
  logic        chk_err;
  logic        ready_q;
  logic        fifo_full;
  logic        fifo_empty;
  logic [32:0] fifo_rdata;

  assign fmt = fmt_e'(in_fmt);

  always_comb begin
    enc_insn = '0;
    fmt_err  = 1'b0;
    case (fmt)
      FMT_R: enc_insn = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: enc_insn = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      FMT_S: enc_insn = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      FMT_B: enc_insn = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], in_opcode};
      FMT_U: enc_insn = {in_imm[31:12], in_rd, in_opcode};
      FMT_J: enc_insn = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                         in_rd, in_opcode};
      default: fmt_err = 1'b1;
    endcase
  end

`ifdef INSN_ENCODE_CHECK_EN
  always_comb begin
    chk_err = 1'b0;
    case (fmt)
      FMT_I, FMT_S: chk_err = !imm_in_range(in_imm, IMM_I_MIN, IMM_I_MAX);
      FMT_B:        chk_err = !imm_in_range(in_imm, IMM_B_MIN, IMM_B_MAX) || in_imm[0];
      FMT_J:        chk_err = !imm_in_range(in_imm, IMM_J_MIN, IMM_J_MAX) || in_imm[0];
      FMT_U:        chk_err = (in_imm[11:0] != 12'd0);
      default:      chk_err = 1'b0;
    endcase
  end
`else
  assign chk_err = 1'b0;
`endif

  // Holds in_ready low while in reset and until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  // Full blocks input even if the head is being popped this cycle.
  assign in_ready = ready_q && !fifo_full;

  insn_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .push_i  (in_valid && in_ready),
    .wdata_i ({fmt_err || chk_err, enc_insn}),
    .pop_i   (out_valid && out_ready),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign out_valid = !fifo_empty;
  assign out_insn  = fifo_rdata[31:0];
  assign out_err   = fifo_rdata[32];

endmodule

// File: tb/tb_insn_encode.sv
module tb_insn_encode;
  import insn_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LVL_W = 3;
`ifdef INSN_ENCODE_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_fmt;
  logic [6:0]       in_opcode;
  logic [4:0]       in_rd;
  logic [2:0]       in_funct3;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [6:0]       in_funct7;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_insn;
  logic             out_err;
  logic [LVL_W-1:0] level;

  insn_encode #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_funct3 (in_funct3),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_insn  (out_insn),
    .out_err   (out_err),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] insn;
    logic        err;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                              input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [6:0] f7, input logic [31:0] imm,
                              input logic [31:0] insn, input logic err);
    vec_t v;
    v.fmt = fmt; v.op = op; v.rd = rd; v.f3 = f3; v.rs1 = rs1; v.rs2 = rs2;
    v.f7 = f7; v.imm = imm; v.insn = insn; v.err = err;
    return v;
  endfunction

  // addi x1, x0, v for small non-negative v.
  function automatic logic [31:0] iword(input int v);
    return (32'(v) << 20) | 32'h0000_0093;
  endfunction

  function automatic vec_t iv(input int v);
    return mk(FMT_I, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'(v), iword(v), 1'b0);
  endfunction

  task automatic drive(input vec_t v);
    in_fmt = v.fmt; in_opcode = v.op; in_rd = v.rd; in_funct3 = v.f3;
    in_rs1 = v.rs1; in_rs2 = v.rs2; in_funct7 = v.f7; in_imm = v.imm;
    in_valid = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushed;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(iv(0));
    in_valid = 1'b0;

    // fmt op rd f3 rs1 rs2 f7 imm -> insn err
    vecs.push_back(mk(FMT_I, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0));
    vecs.push_back(mk(FMT_R, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'hDEAD_BEEF,
                      32'h0020_81B3, 1'b0));
    vecs.push_back(mk(FMT_S, 7'h23, 5'd31, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8, 32'h0020_A423, 1'b0));
    vecs.push_back(mk(FMT_B, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFF_FFFC,
                      32'hFE20_8EE3, 1'b0));
    vecs.push_back(mk(FMT_U, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5000,
                      32'h1234_52B7, 1'b0));
    vecs.push_back(mk(FMT_J, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd3, 32'h0020_00EF, CHK));
    vecs.push_back(mk(FMT_I, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd4096, 32'h0000_0093, CHK));
    vecs.push_back(mk(3'd7, 7'h13, 5'd1, 3'd1, 5'd1, 5'd1, 7'd1, 32'd1, 32'h0, 1'b1));
    vecs.push_back(mk(3'd6, 7'h33, 5'd2, 3'd2, 5'd2, 5'd2, 7'd2, 32'd0, 32'h0, 1'b1));
    vecs.push_back(mk(FMT_J, 7'h6F, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048, 32'h0010_006F, 1'b0));
    vecs.push_back(mk(FMT_B, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd4094, 32'h7E00_0FE3, 1'b0));
    vecs.push_back(mk(FMT_B, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd4096, 32'h8000_0063, CHK));
    vecs.push_back(mk(FMT_B, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5, 32'h0000_0263, CHK));
    vecs.push_back(mk(FMT_I, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_F800,
                      32'h8000_0013, 1'b0));
    vecs.push_back(mk(FMT_I, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2047, 32'h7FF0_0013, 1'b0));
    vecs.push_back(mk(FMT_S, 7'h23, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_F7FF,
                      32'h7E00_0FA3, CHK));
    vecs.push_back(mk(FMT_U, 7'h37, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5001,
                      32'h1234_5037, CHK));
    vecs.push_back(mk(FMT_J, 7'h6F, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFF0_0000,
                      32'h8000_006F, 1'b0));
    vecs.push_back(mk(FMT_J, 7'h6F, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'h0010_0000,
                      32'h8000_006F, CHK));

    // Reset state
    #12;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst level", 32'(level), 32'd0);
    chk("rst out_insn", out_insn, 32'd0);
    chk("rst out_err", 32'(out_err), 32'd0);
    #10 rst_n = 1'b1;
    tick();
    chk("post-rst in_ready", 32'(in_ready), 32'd1);

    // Format packing, out_ready held high
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("vec%0d no pass-through", i), 32'(out_valid), 32'd0);
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d out_insn", i), out_insn, vecs[i].insn);
      chk($sformatf("vec%0d out_err", i), 32'(out_err), 32'(vecs[i].err));
      tick();
      chk($sformatf("vec%0d drained", i), 32'(level), 32'd0);
    end

    // Backpressure: fill, hold a 5th tuple, free one slot
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive(iv(k));
      tick();
    end
    in_valid = 1'b0;
    chk("bp full level", 32'(level), 32'd4);
    chk("bp full in_ready", 32'(in_ready), 32'd0);
    drive(iv(5));
    tick();
    chk("bp held level", 32'(level), 32'd4);
    chk("bp head stable", out_insn, iword(1));
    out_ready = 1'b1;
    #1;
    chk("bp full in_ready during pop", 32'(in_ready), 32'd0);
    tick();
    out_ready = 1'b0;
    chk("bp level after pop", 32'(level), 32'd3);
    chk("bp in_ready after pop", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp refill level", 32'(level), 32'd4);
    out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("bp order %0d", k), out_insn, iword(k));
      tick();
    end
    chk("bp drained", 32'(level), 32'd0);

    // Interleaved stream across pointer wrap, scoreboard-checked
    pushed = 0;
    for (int c = 0; c < 60 && (pushed < 10 || exp_q.size() > 0); c++) begin
      if (pushed < 10 && (c % 3 != 2)) drive(iv(100 + pushed));
      else in_valid = 1'b0;
      out_ready = (c % 4 != 0);
      #3;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("stream spurious word", out_insn, 32'hFFFF_FFFF);
        else chk($sformatf("stream order c%0d", c), out_insn, exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(iword(100 + pushed));
        pushed++;
      end
      tick();
    end
    in_valid = 1'b0;
    chk("stream pushes", 32'(pushed), 32'd10);
    chk("stream leftover", 32'(exp_q.size()), 32'd0);
    chk("stream level", 32'(level), 32'd0);

    // Flush with a same-cycle push
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(iv(200 + k));
      tick();
    end
    in_valid = 1'b0;
    chk("flush pre level", 32'(level), 32'd3);
    drive(iv(300));
    flush = 1'b1;
    #1;
    chk("flush in_ready", 32'(in_ready), 32'd1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush level", 32'(level), 32'd0);
    chk("flush out_valid", 32'(out_valid), 32'd0);
    drive(iv(400));
    tick();
    in_valid = 1'b0;
    chk("post-flush head", out_insn, iword(400));
    out_ready = 1'b1;
    tick();
    chk("post-flush drained", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    drive(iv(500));
    tick();
    drive(iv(501));
    tick();
    in_valid = 1'b0;
    chk("rst2 pre level", 32'(level), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2 out_valid", 32'(out_valid), 32'd0);
    chk("rst2 level", 32'(level), 32'd0);
    chk("rst2 out_insn", out_insn, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst2 in_ready", 32'(in_ready), 32'd1);
    drive(iv(600));
    tick();
    in_valid = 1'b0;
    chk("rst2 first out_valid", 32'(out_valid), 32'd1);
    chk("rst2 first out_insn", out_insn, iword(600));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
